// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: captures bytes on rx_done,
// streams them out over valid/ready, and keeps overrun and framing-error statistics.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_done,
  input  logic                    rx_err,
  input  logic                    clear,
  output logic [7:0]              m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    overrun,
  output logic [CNT_W-1:0]        err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_dly_q;

  logic empty;
  logic push, pop, drop, err_rise;

  // Every output is decoded from registered pointers/flags only, so there is
  // no combinational path from rx_done or m_ready to any output.
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level    = wptr_q - rptr_q;
  assign m_valid  = !empty;
  assign m_data   = mem_q[rptr_q[AW-1:0]];
  assign overrun  = overrun_q;
  assign err_count = err_cnt_q;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign pop      = m_valid && m_ready;
  assign push     = rx_done && (!full || pop);
  assign drop     = rx_done && full && !pop;
  assign err_rise = rx_err && !err_dly_q;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    overrun_d = overrun_q;
    err_cnt_d = err_cnt_q;
    if (clear) begin
      wptr_d    = '0;
      rptr_d    = '0;
      overrun_d = 1'b0;
      err_cnt_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      if (drop) overrun_d = 1'b1;
      if (err_rise && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      overrun_q <= 1'b0;
      err_cnt_q <= '0;
      err_dly_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      overrun_q <= overrun_d;
      err_cnt_q <= err_cnt_d;
      // Keeps sampling during clear so a level already high is not recounted.
      err_dly_q <= rx_err;
      if (push && !clear) mem_q[wptr_q[AW-1:0]] <= rx_data;
    end
  end

endmodule
